// File: rtl/vga_pkg.sv
// Shared VGA timing definitions.
//   vga_mode_t : per-mode horizontal/vertical timing plus sync polarity
//   VGA_MODES  : mode table, index 0 = 640x480@60, index 1 = 800x600@60
//   vga_t      : sync/blank bundle; vga_ext_t adds sof/eol strobes and mode
//   h_total/v_total : full line/frame lengths of a mode
package vga_pkg;

  typedef struct packed {
    logic [15:0] h_act;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_act;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        pol;   // 1 = sync pulses are active high
  } vga_mode_t;

  localparam vga_mode_t VGA_MODES [2] = '{
    '{h_act: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
      v_act: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33, pol: 1'b0},
    '{h_act: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
      v_act: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23, pol: 1'b1}
  };

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } vga_t;

  typedef struct packed {
    vga_t base;
    logic sof;
    logic eol;
    logic mode;
  } vga_ext_t;

  function automatic logic [15:0] h_total(input vga_mode_t m);
    return m.h_act + m.h_fp + m.h_sync + m.h_bp;
  endfunction

  function automatic logic [15:0] v_total(input vga_mode_t m);
    return m.v_act + m.v_fp + m.v_sync + m.v_bp;
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing bus between the timing generator (src) and its consumers (snk).
//   hcount_out/vcount_out : pixel column/row
//   hsync_out/vsync_out   : syncs at pin polarity
//   blank_out             : 1 outside the active area
//   sof_out/eol_out       : start-of-frame / last-active-pixel strobes
//   mode_out              : mode used by the current output frame
//   frame_cnt_out         : completed-frame count, wraps
interface vga_if #(
  parameter int HCOUNT_WIDTH    = 11,
  parameter int VCOUNT_WIDTH    = 10,
  parameter int FRAME_CNT_WIDTH = 8
);
  logic [HCOUNT_WIDTH-1:0]    hcount_out;
  logic [VCOUNT_WIDTH-1:0]    vcount_out;
  logic                       hsync_out;
  logic                       vsync_out;
  logic                       blank_out;
  logic                       sof_out;
  logic                       eol_out;
  logic                       mode_out;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_out;

  modport src (output hcount_out, vcount_out, hsync_out, vsync_out, blank_out,
               sof_out, eol_out, mode_out, frame_cnt_out);
  modport snk (input  hcount_out, vcount_out, hsync_out, vsync_out, blank_out,
               sof_out, eol_out, mode_out, frame_cnt_out);
endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register, DEPTH stages of WIDTH bits, async active-low
// reset to RST_VAL. Used to align timing signals with a pixel pipeline.
//   clk_i, rst_ni : clock, async reset
//   en_i          : all stages advance together only when high
//   d_i / q_o     : input word / word delayed by DEPTH enabled cycles
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Two-mode VGA timing generator (640x480@60 / 800x600@60) driving vga_if.src.
//   clk_in     : system clock
//   rst_n_in   : async reset, active low
//   pix_en_in  : pixel enable; counters and output pipeline advance only when high
//   mode_in    : requested mode, adopted only when the frame wraps
//   vga        : timing bus, delayed PIPE_DELAY enabled cycles from the counters
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HCOUNT_WIDTH    = 11,
  parameter int VCOUNT_WIDTH    = 10,
  parameter int PIPE_DELAY      = 2,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic pix_en_in,
  input  logic mode_in,
  vga_if.src   vga
);

  for (genvar i = 0; i < 2; i++) begin : g_mode_chk
    if (int'(h_total(VGA_MODES[i])) > (2 ** HCOUNT_WIDTH)) begin : g_h_bad
      $error("HCOUNT_WIDTH too small for mode %0d", i);
    end
    if (int'(v_total(VGA_MODES[i])) > (2 ** VCOUNT_WIDTH)) begin : g_v_bad
      $error("VCOUNT_WIDTH too small for mode %0d", i);
    end
  end
  if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_pipe_bad
    $error("PIPE_DELAY must be 1..8");
  end

  typedef struct packed {
    logic [HCOUNT_WIDTH-1:0]    hc;
    logic [VCOUNT_WIDTH-1:0]    vc;
    logic [FRAME_CNT_WIDTH-1:0] fc;
    vga_ext_t                   ctl;
  } bundle_t;

  // Mode-0 idle levels: syncs inactive (high), blanked, no strobes.
  localparam bundle_t BUNDLE_RST = '{
    hc: '0, vc: '0, fc: '0,
    ctl: '{base: '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1},
           sof: 1'b0, eol: 1'b0, mode: 1'b0}};

  logic [HCOUNT_WIDTH-1:0]    hc_q, hc_d;
  logic [VCOUNT_WIDTH-1:0]    vc_q, vc_d;
  logic [FRAME_CNT_WIDTH-1:0] fc_q, fc_d;
  logic                       mode_q, mode_d;

  vga_mode_t   cfg;
  logic [15:0] hc_w, vc_w;
  logic        h_last, v_last, h_in, v_in;
  bundle_t     dec, out_b;
  logic [$bits(bundle_t)-1:0] out_vec;

  assign cfg    = VGA_MODES[mode_q];
  assign hc_w   = 16'(hc_q);
  assign vc_w   = 16'(vc_q);
  assign h_last = (hc_w == h_total(cfg) - 16'd1);
  assign v_last = (vc_w == v_total(cfg) - 16'd1);

  // Mode is only latched at the full-frame wrap, so a frame never mixes two
  // timing tables and a request withdrawn before the wrap is never seen.
  always_comb begin
    hc_d   = hc_q;
    vc_d   = vc_q;
    fc_d   = fc_q;
    mode_d = mode_q;
    if (pix_en_in) begin
      if (h_last) begin
        hc_d = '0;
        if (v_last) begin
          vc_d   = '0;
          fc_d   = fc_q + FRAME_CNT_WIDTH'(1);
          mode_d = mode_in;
        end else begin
          vc_d = vc_q + VCOUNT_WIDTH'(1);
        end
      end else begin
        hc_d = hc_q + HCOUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hc_q   <= '0;
      vc_q   <= '0;
      fc_q   <= '0;
      mode_q <= 1'b0;
    end else begin
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      fc_q   <= fc_d;
      mode_q <= mode_d;
    end
  end

  // Decode stage: counters -> sync/blank/strobes
  always_comb begin
    h_in = (hc_w >= cfg.h_act + cfg.h_fp) &&
           (hc_w <  cfg.h_act + cfg.h_fp + cfg.h_sync);
    v_in = (vc_w >= cfg.v_act + cfg.v_fp) &&
           (vc_w <  cfg.v_act + cfg.v_fp + cfg.v_sync);
    dec                = BUNDLE_RST;
    dec.hc             = hc_q;
    dec.vc             = vc_q;
    dec.fc             = fc_q;
    dec.ctl.base.hsync = h_in ? cfg.pol : ~cfg.pol;
    dec.ctl.base.vsync = v_in ? cfg.pol : ~cfg.pol;
    dec.ctl.base.blank = (hc_w >= cfg.h_act) || (vc_w >= cfg.v_act);
    dec.ctl.sof        = (hc_q == '0) && (vc_q == '0);
    dec.ctl.eol        = (hc_w == cfg.h_act - 16'd1) && (vc_w < cfg.v_act);
    dec.ctl.mode       = mode_q;
  end

  // Output pipeline: PIPE_DELAY enabled stages
  vga_delay_line #(
    .WIDTH   ($bits(bundle_t)),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (BUNDLE_RST)
  ) u_dly (
    .clk_i  (clk_in),
    .rst_ni (rst_n_in),
    .en_i   (pix_en_in),
    .d_i    (dec),
    .q_o    (out_vec)
  );

  assign out_b             = bundle_t'(out_vec);
  assign vga.hcount_out    = out_b.hc;
  assign vga.vcount_out    = out_b.vc;
  assign vga.frame_cnt_out = out_b.fc;
  assign vga.hsync_out     = out_b.ctl.base.hsync;
  assign vga.vsync_out     = out_b.ctl.base.vsync;
  assign vga.blank_out     = out_b.ctl.base.blank;
  assign vga.sof_out       = out_b.ctl.sof;
  assign vga.eol_out       = out_b.ctl.eol;
  assign vga.mode_out      = out_b.ctl.mode;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a vector table for the first lines after
// reset, then hand-written sequences for frame wrap, mode switching, reset,
// frame counter wrap and pixel-enable gating. Frame ends are reached by
// forcing the row/frame counters forward instead of simulating whole frames.
module tb_vga_timing_gen;
  localparam int HW = 11, VW = 10, FW = 8, PD = 2;

  logic clk = 1'b0, rst_n = 1'b0, pix_en = 1'b1, mode = 1'b0;
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  vga_if #(.HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW), .FRAME_CNT_WIDTH(FW)) vif ();

  vga_timing_gen #(.HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW), .PIPE_DELAY(PD),
                   .FRAME_CNT_WIDTH(FW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .pix_en_in(pix_en), .mode_in(mode), .vga(vif));

  always #5 clk = ~clk;

  typedef struct {
    int k;
    int hc, vc, hs, vs, bl, sof, eol;
  } vec_t;
  vec_t vt [13];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int eol_n, hs_n, hs_first, bad_n, vs_first, budget, fprev, sof_c, hold_d, c_sof, c_v1;
    logic [HW-1:0] h0;
    logic found;

    // cycle k after reset release: output shows counter position k-2 (mode 0)
    vt[0]  = '{0,    0,   0, 1, 1, 1, 0, 0};
    vt[1]  = '{1,    0,   0, 1, 1, 1, 0, 0};
    vt[2]  = '{2,    0,   0, 1, 1, 0, 1, 0};
    vt[3]  = '{3,    1,   0, 1, 1, 0, 0, 0};
    vt[4]  = '{641,  639, 0, 1, 1, 0, 0, 1};
    vt[5]  = '{642,  640, 0, 1, 1, 1, 0, 0};
    vt[6]  = '{657,  655, 0, 1, 1, 1, 0, 0};
    vt[7]  = '{658,  656, 0, 0, 1, 1, 0, 0};
    vt[8]  = '{753,  751, 0, 0, 1, 1, 0, 0};
    vt[9]  = '{754,  752, 0, 1, 1, 1, 0, 0};
    vt[10] = '{801,  799, 0, 1, 1, 1, 0, 0};
    vt[11] = '{802,  0,   1, 1, 1, 0, 0, 0};
    vt[12] = '{1441, 639, 1, 1, 1, 0, 0, 1};

    // ---- reset state ----
    repeat (3) tick();
    chk("rst.mode", int'(vif.mode_out), 0);
    chk("rst.fcnt", int'(vif.frame_cnt_out), 0);
    rst_n = 1'b1;
    cyc = 0;

    // ---- vector table, mode 0 ----
    for (int i = 0; i < 13; i++) begin
      while (cyc < vt[i].k) tick();
      chk($sformatf("v%0d.hc", i),  int'(vif.hcount_out), vt[i].hc);
      chk($sformatf("v%0d.vc", i),  int'(vif.vcount_out), vt[i].vc);
      chk($sformatf("v%0d.hs", i),  int'(vif.hsync_out),  vt[i].hs);
      chk($sformatf("v%0d.vs", i),  int'(vif.vsync_out),  vt[i].vs);
      chk($sformatf("v%0d.bl", i),  int'(vif.blank_out),  vt[i].bl);
      chk($sformatf("v%0d.sof", i), int'(vif.sof_out),    vt[i].sof);
      chk($sformatf("v%0d.eol", i), int'(vif.eol_out),    vt[i].eol);
    end

    // ---- hsync width/position on line 2, eol per line, lines 2..9 ----
    eol_n = 0; hs_n = 0; hs_first = -1;
    while (cyc < 8001) begin
      tick();
      if (vif.eol_out) eol_n++;
      if (cyc >= 1602 && cyc <= 2401 && !vif.hsync_out) begin
        if (hs_first < 0) hs_first = int'(vif.hcount_out);
        hs_n++;
      end
    end
    chk("m0.hs_low_len", hs_n, 96);
    chk("m0.hs_low_start", hs_first, 656);
    chk("m0.eol_lines2to9", eol_n, 8);
    chk("m0.line9_end_hc", int'(vif.hcount_out), 799);
    chk("m0.line9_end_vc", int'(vif.vcount_out), 9);

    // ---- mid-frame mode request, jump to row 488, run to frame wrap ----
    mode = 1'b1;
    force dut.vc_q = 10'd488;
    tick();
    release dut.vc_q;
    bad_n = 0; eol_n = 0; hs_n = 0; vs_first = -1; found = 1'b0;
    for (budget = 0; budget < 40000; budget++) begin
      tick();
      if (vif.sof_out) begin found = 1'b1; break; end
      if (vif.mode_out) bad_n++;
      if (vif.eol_out) eol_n++;
      if (!vif.vsync_out) begin
        if (vs_first < 0) vs_first = int'(vif.vcount_out);
        hs_n++;
      end
    end
    chk("sw.sof_seen", int'(found), 1);
    chk("sw.mode_early", bad_n, 0);
    chk("vb.eol_none", eol_n, 0);
    chk("m0.vs_low_len", hs_n, 1600);
    chk("m0.vs_low_row", vs_first, 490);
    chk("sw.mode_after", int'(vif.mode_out), 1);
    chk("sw.fcnt", int'(vif.frame_cnt_out), 1);
    chk("sw.vc0", int'(vif.vcount_out), 0);
    chk("sw.blank0", int'(vif.blank_out), 0);

    // ---- first line of mode 1 ----
    hs_n = 0; hs_first = -1; eol_n = 0; vs_first = -1;
    for (int j = 1; j <= 1056; j++) begin
      tick();
      if (j < 1056) begin
        if (vif.hsync_out) begin
          if (hs_first < 0) hs_first = int'(vif.hcount_out);
          hs_n++;
        end
        if (vif.eol_out) begin eol_n++; vs_first = int'(vif.hcount_out); end
      end
    end
    chk("m1.hs_high_len", hs_n, 128);
    chk("m1.hs_high_start", hs_first, 840);
    chk("m1.eol_cnt", eol_n, 1);
    chk("m1.eol_hc", vs_first, 799);
    chk("m1.period_hc", int'(vif.hcount_out), 0);
    chk("m1.period_vc", int'(vif.vcount_out), 1);

    // ---- request toggled 1->0->1 before wrap: mode stays 1 ----
    mode = 1'b0;
    force dut.vc_q = 10'd598;
    tick();
    release dut.vc_q;
    bad_n = 0; hs_n = 0; vs_first = -1; found = 1'b0;
    for (budget = 0; budget < 40000; budget++) begin
      tick();
      if (budget == 300) mode = 1'b1;
      if (vif.sof_out) begin found = 1'b1; break; end
      if (!vif.mode_out) bad_n++;
      if (vif.vsync_out) begin
        if (vs_first < 0) vs_first = int'(vif.vcount_out);
        hs_n++;
      end
    end
    chk("tg.sof_seen", int'(found), 1);
    chk("tg.mode_mid", bad_n, 0);
    chk("m1.vs_high_len", hs_n, 4224);
    chk("m1.vs_high_row", vs_first, 601);
    chk("tg.mode_after", int'(vif.mode_out), 1);
    chk("tg.fcnt", int'(vif.frame_cnt_out), 2);

    // ---- async reset mid-line in mode 1 ----
    repeat (500) tick();
    chk("pre.hs", int'(vif.hsync_out), 0);
    chk("pre.bl", int'(vif.blank_out), 0);
    rst_n = 1'b0;
    #1;
    chk("ar.hc", int'(vif.hcount_out), 0);
    chk("ar.vc", int'(vif.vcount_out), 0);
    chk("ar.bl", int'(vif.blank_out), 1);
    chk("ar.hs", int'(vif.hsync_out), 1);
    chk("ar.vs", int'(vif.vsync_out), 1);
    chk("ar.mode", int'(vif.mode_out), 0);
    chk("ar.fcnt", int'(vif.frame_cnt_out), 0);
    chk("ar.sof", int'(vif.sof_out), 0);
    tick();
    tick();
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 2) tick();
    chk("rr.sof", int'(vif.sof_out), 1);
    chk("rr.mode", int'(vif.mode_out), 0);
    while (cyc < 802) tick();
    chk("rr.period_hc", int'(vif.hcount_out), 0);
    chk("rr.period_vc", int'(vif.vcount_out), 1);

    // ---- frame counter wrap 255 -> 0 at sof ----
    mode = 1'b0;
    force dut.fc_q = 8'hFF;
    force dut.vc_q = 10'd524;
    tick();
    release dut.fc_q;
    release dut.vc_q;
    fprev = -1; found = 1'b0;
    for (budget = 0; budget < 2000; budget++) begin
      tick();
      if (vif.sof_out) begin found = 1'b1; break; end
      fprev = int'(vif.frame_cnt_out);
    end
    chk("fw.sof_seen", int'(found), 1);
    chk("fw.before", fprev, 255);
    chk("fw.at_sof", int'(vif.frame_cnt_out), 0);

    // ---- pixel enable one clock in four ----
    rst_n = 1'b0;
    tick();
    pix_en = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
    sof_c = 0; hold_d = 0; c_sof = -1; c_v1 = -1;
    for (int g = 0; g < 900 && c_v1 < 0; g++) begin
      pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      h0 = vif.hcount_out;
      if (vif.sof_out) begin sof_c++; if (c_sof < 0) c_sof = cyc; end
      if (vif.vcount_out == VW'(1)) c_v1 = cyc;
      for (int t = 0; t < 3; t++) begin
        tick();
        if (vif.sof_out) sof_c++;
        if (vif.hcount_out != h0) hold_d++;
      end
    end
    chk("pe.sof_clks", sof_c, 4);
    chk("pe.hold", hold_d, 0);
    chk("pe.sof_cyc", c_sof, 5);
    chk("pe.line_period", c_v1 - c_sof, 3200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
